// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation mode encoding, the result flag bundle and
// the mode-to-carry-in mapping used by the add/subtract pipeline.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_ADC = 2'b10;
    localparam logic [1:0] ALU_SBB = 2'b11;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } alu_flags_t;

    // Subtract is A + ~B + 1; the extended modes take their carry from the caller.
    function automatic logic mode_cin(input logic [1:0] mode, input logic cin);
        logic c;
        case (mode)
            ALU_ADD: c = 1'b0;
            ALU_SUB: c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/int_add_sub_stage.sv
// One registered chunk of the pipelined adder: adds chunk IDX of the operands
// with the incoming carry and forwards operands, partial result and carry-out.
module int_add_sub_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             in_valid,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_res,
    output logic             out_valid,
    output logic             out_carry,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_res
);

    localparam int LSB = IDX * CHUNK;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        sum      = {1'b0, in_a[LSB +: CHUNK]} + {1'b0, in_b[LSB +: CHUNK]}
                 + {{CHUNK{1'b0}}, in_cin};
        res_next = in_res;
        res_next[LSB +: CHUNK] = sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_carry <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_res   <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_carry <= sum[CHUNK];
            out_a     <= in_a;
            out_b     <= in_b;
            out_res   <= res_next;
        end
    end

endmodule

// File: rtl/int_add_sub_pipe.sv
// Pipelined integer add/subtract, one WIDTH/STAGES-bit chunk per stage with the carry
// rippling through registers. Define INT_ADD_SUB_SAT_EN to enable signed saturation on i_sat.
module int_add_sub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_mode,
    input  logic             i_cin,
    input  logic             i_sat,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output logic             o_negative
);

    localparam int CHUNK = WIDTH / STAGES;

    // Handshake: a request enters on i_valid && o_ready, a result leaves on o_valid && i_ready.
    // The whole pipeline moves together whenever the output slot is empty or being drained.
    logic adv;
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    // Index 0 is the pipeline input, index k+1 the register of stage k.
    logic [STAGES:0]  vld;
    logic [STAGES:0]  cry;
    logic [WIDTH-1:0] op_a      [STAGES+1];
    logic [WIDTH-1:0] op_b      [STAGES+1];
    logic [WIDTH-1:0] stage_res [STAGES+1];

    assign vld[0]       = i_valid;
    assign cry[0]       = mode_cin(i_mode, i_cin);
    assign op_a[0]      = i_a;
    assign op_b[0]      = i_b ^ {WIDTH{i_mode[0]}};
    assign stage_res[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        int_add_sub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (i_clk),
            .rst       (i_rst),
            .adv       (adv),
            .in_valid  (vld[k]),
            .in_cin    (cry[k]),
            .in_a      (op_a[k]),
            .in_b      (op_b[k]),
            .in_res    (stage_res[k]),
            .out_valid (vld[k+1]),
            .out_carry (cry[k+1]),
            .out_a     (op_a[k+1]),
            .out_b     (op_b[k+1]),
            .out_res   (stage_res[k+1])
        );
    end

    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] result;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             unused_ok;

    assign raw   = stage_res[STAGES];
    assign a_msb = op_a[STAGES][WIDTH-1];
    assign b_msb = op_b[STAGES][WIDTH-1];
    assign ovf   = (a_msb == b_msb) && (raw[WIDTH-1] != a_msb);

`ifdef INT_ADD_SUB_SAT_EN
    logic [STAGES-1:0] sat_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sat_q <= '0;
        end else if (adv) begin
            sat_q[0] <= i_sat;
            for (int k = 1; k < STAGES; k++) sat_q[k] <= sat_q[k-1];
        end
    end

    always_comb begin
        result = raw;
        if (sat_q[STAGES-1] && ovf)
            result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    assign unused_ok = ^{op_a[STAGES][WIDTH-2:0], op_b[STAGES][WIDTH-2:0]};
`else
    assign result    = raw;
    assign unused_ok = ^{i_sat, op_a[STAGES][WIDTH-2:0], op_b[STAGES][WIDTH-2:0]};
`endif

    // Zero is qualified by valid so the idle/reset output presents all-zero flags.
    alu_flags_t flags;
    always_comb begin
        flags.carry    = cry[STAGES];
        flags.overflow = ovf;
        flags.zero     = o_valid && (result == '0);
        flags.negative = result[WIDTH-1];
    end

    assign o_valid    = vld[STAGES];
    assign o_result   = result;
    assign o_carry    = flags.carry;
    assign o_overflow = flags.overflow;
    assign o_zero     = flags.zero;
    assign o_negative = flags.negative;

endmodule

// File: tb/tb_int_add_sub_pipe.sv
// Bench for int_add_sub_pipe: directed vectors and stall/reset sequences on a 32/2 build,
// randomized streams on 16/4 and 64/1 builds against a whole-word arithmetic model.
module tb_int_add_sub_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a_s[3], b_s[3];
  logic [1:0]  mode_s[3];
  logic        valid_s[3], cin_s[3], sat_s[3], ready_s[3];
  logic [63:0] res_o[3];
  logic        ovalid_o[3], oready_o[3], c_o[3], v_o[3], z_o[3], n_o[3];
  logic [31:0] r0;
  logic [15:0] r1;
  logic [63:0] r2;

  assign res_o[0] = {32'd0, r0};
  assign res_o[1] = {48'd0, r1};
  assign res_o[2] = r2;

  int checks = 0;
  int failures = 0;
  logic [67:0] exp_q[$];

  typedef struct {
    logic [1:0]  mode;
    logic        cin;
    logic        sat;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs[14];

  int_add_sub_pipe #(.WIDTH(32), .STAGES(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_s[0]), .o_ready(oready_o[0]),
    .i_mode(mode_s[0]), .i_cin(cin_s[0]), .i_sat(sat_s[0]),
    .i_a(a_s[0][31:0]), .i_b(b_s[0][31:0]), .o_valid(ovalid_o[0]), .i_ready(ready_s[0]),
    .o_result(r0), .o_carry(c_o[0]), .o_overflow(v_o[0]), .o_zero(z_o[0]), .o_negative(n_o[0]));

  int_add_sub_pipe #(.WIDTH(16), .STAGES(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_s[1]), .o_ready(oready_o[1]),
    .i_mode(mode_s[1]), .i_cin(cin_s[1]), .i_sat(sat_s[1]),
    .i_a(a_s[1][15:0]), .i_b(b_s[1][15:0]), .o_valid(ovalid_o[1]), .i_ready(ready_s[1]),
    .o_result(r1), .o_carry(c_o[1]), .o_overflow(v_o[1]), .o_zero(z_o[1]), .o_negative(n_o[1]));

  int_add_sub_pipe #(.WIDTH(64), .STAGES(1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_s[2]), .o_ready(oready_o[2]),
    .i_mode(mode_s[2]), .i_cin(cin_s[2]), .i_sat(sat_s[2]),
    .i_a(a_s[2]), .i_b(b_s[2]), .o_valid(ovalid_o[2]), .i_ready(ready_s[2]),
    .o_result(r2), .o_carry(c_o[2]), .o_overflow(v_o[2]), .o_zero(z_o[2]), .o_negative(n_o[2]));

  function automatic int width_of(input int j);
    return (j == 0) ? 32 : (j == 1) ? 16 : 64;
  endfunction

  // Reference: whole-word two's-complement arithmetic; returns {carry, ovf, zero, neg, result}.
  function automatic logic [67:0] model(input int w, input logic [1:0] mode, input logic cin,
                                        input logic sat, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] mask, beff, sum;
    logic [63:0] res;
    logic        ci, c, v, z, n, am, bm, rm;
    mask = (65'd1 << w) - 65'd1;
    beff = mode[0] ? ({1'b0, ~b} & mask) : ({1'b0, b} & mask);
    ci   = (mode == 2'b00) ? 1'b0 : (mode == 2'b01) ? 1'b1 : cin;
    sum  = ({1'b0, a} & mask) + beff + 65'(ci);
    res  = sum[63:0] & mask[63:0];
    c    = sum[w];
    am   = a[w-1];
    bm   = beff[w-1];
    rm   = res[w-1];
    v    = (am == bm) && (rm != am);
`ifdef INT_ADD_SUB_SAT_EN
    if (sat && v) res = am ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`else
    if (sat && 1'b0) res = '0;
`endif
    z = (res == 64'd0);
    n = res[w-1];
    return {c, v, z, n, res};
  endfunction

  function automatic logic [63:0] rand_op(input int w);
    logic [63:0] mask, v;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = mask;
      2:       v = 64'd1 << (w-1);
      3:       v = (64'd1 << (w-1)) - 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input int j, input logic [67:0] e, input string tag);
    check({tag, "_result"},   res_o[j], e[63:0]);
    check({tag, "_carry"},    64'(c_o[j]), 64'(e[67]));
    check({tag, "_overflow"}, 64'(v_o[j]), 64'(e[66]));
    check({tag, "_zero"},     64'(z_o[j]), 64'(e[65]));
    check({tag, "_negative"}, 64'(n_o[j]), 64'(e[64]));
  endtask

  // Called at a negedge with inputs already driven; books this cycle's handshakes.
  task automatic step(input int j, output bit acc, output bit free);
    #1;
    if (ovalid_o[j]) begin
      if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
      else begin
        check_out(j, exp_q[0], "stream");
        if (ready_s[j]) void'(exp_q.pop_front());
      end
    end
    acc  = valid_s[j] && oready_o[j];
    free = !valid_s[j] || oready_o[j];
    if (acc) exp_q.push_back(model(width_of(j), mode_s[j], cin_s[j], sat_s[j], a_s[j], b_s[j]));
    @(negedge clk);
  endtask

  task automatic rand_req(input int j);
    mode_s[j] = 2'($urandom_range(0, 3));
    cin_s[j]  = 1'($urandom_range(0, 1));
    sat_s[j]  = 1'($urandom_range(0, 1));
    a_s[j]    = rand_op(width_of(j));
    b_s[j]    = rand_op(width_of(j));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    mode_s[0] = v.mode; cin_s[0] = v.cin; sat_s[0] = v.sat;
    a_s[0] = {32'd0, v.a}; b_s[0] = {32'd0, v.b};
    ready_s[0] = 1'b1; valid_s[0] = 1'b1;
    @(negedge clk);
    valid_s[0] = 1'b0;
    lat = 1;
    while (!ovalid_o[0] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd2);
    check_out(0, {v.c, v.v, v.z, v.n, 32'd0, v.res}, tag);
    @(negedge clk);
  endtask

  task automatic run_random(input int j, input int n);
    bit acc, free;
    exp_q.delete();
    free = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (free) begin
        valid_s[j] = ($urandom_range(0, 3) != 0);
        rand_req(j);
      end
      ready_s[j] = ($urandom_range(0, 3) != 0);
      step(j, acc, free);
    end
    valid_s[j] = 1'b0;
    ready_s[j] = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step(j, acc, free);
    check($sformatf("random%0d_drained", j), 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit acc, free;
    int sent, bad;

    vecs[0]  = '{2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{2'b01, 1'b0, 1'b0, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef INT_ADD_SUB_SAT_EN
    vecs[2]  = '{2'b01, 1'b0, 1'b1, 32'h80000000, 32'h1,        32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vecs[2]  = '{2'b01, 1'b0, 1'b1, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    vecs[3]  = '{2'b11, 1'b0, 1'b0, 32'h5,        32'h7,        32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{2'b10, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{2'b00, 1'b0, 1'b0, 32'h1,        32'h2,        32'h3,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 1'b0, 1'b0, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'b10, 1'b1, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{2'b11, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{2'b00, 1'b0, 1'b0, 32'h0000FFFF, 32'h1,        32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 1'b1, 1'b0, 32'h0,        32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 1'b0, 1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{2'b00, 1'b1, 1'b0, 32'h1,        32'h1,        32'h2,        1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{2'b01, 1'b0, 1'b0, 32'h3,        32'h1,        32'h2,        1'b1, 1'b0, 1'b0, 1'b0};

    // Clock/reset
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      valid_s[j] = 1'b0; ready_s[j] = 1'b1; mode_s[j] = 2'b00;
      cin_s[j] = 1'b0; sat_s[j] = 1'b0; a_s[j] = 64'd0; b_s[j] = 64'd0;
    end
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset%0d_o_valid", j), 64'(ovalid_o[j]), 64'd0);
      check($sformatf("reset%0d_result", j), res_o[j], 64'd0);
      check($sformatf("reset%0d_flags", j), 64'({c_o[j], v_o[j], z_o[j], n_o[j]}), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int j = 0; j < 3; j++) check($sformatf("reset%0d_o_ready", j), 64'(oready_o[j]), 64'd1);
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream of 8 with the sink stalled in cycles 3..5
    exp_q.delete();
    sent = 0;
    free = 1'b1;
    for (int c = 0; c < 40 && !(sent == 8 && exp_q.size() == 0); c++) begin
      if (free) begin
        valid_s[0] = (sent < 8);
        rand_req(0);
      end
      ready_s[0] = !(c >= 3 && c <= 5);
      if (!ready_s[0]) begin
        #1;
        check($sformatf("stall_o_ready_c%0d", c), 64'(oready_o[0]), 64'd0);
      end
      step(0, acc, free);
      if (acc) sent++;
    end
    valid_s[0] = 1'b0;
    ready_s[0] = 1'b1;
    check("stall_sent", 64'(sent), 64'd8);
    check("stall_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Reset with two requests in flight
    mode_s[0] = 2'b00; a_s[0] = 64'd10; b_s[0] = 64'd20; valid_s[0] = 1'b1;
    @(negedge clk);
    a_s[0] = 64'd30; b_s[0] = 64'd40;
    @(negedge clk);
    valid_s[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_o_valid", 64'(ovalid_o[0]), 64'd0);
    check("midrst_result", res_o[0], 64'd0);
    check("midrst_flags", 64'({c_o[0], v_o[0], z_o[0], n_o[0]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_o_ready", 64'(oready_o[0]), 64'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ovalid_o[0]) bad = 1;
    end
    check("midrst_no_stale", 64'(bad), 64'd0);
    run_vec(vecs[5], "post_rst");

    // Randomized regression on the other builds
    run_random(1, 400);
    run_random(2, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
